// File: rtl/tank_pkg.sv
// Shared tank/bullet types: facing direction, keyboard codes and screen limits.
package tank_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_ENTER = 8'h58;

    localparam logic [9:0] X_MAX = 10'd639;
    localparam logic [9:0] Y_MAX = 10'd479;

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: holds position/direction, loads on spawn, moves or retires
// on each frame tick, and flags whether the current pixel falls inside it.
module bullet_slot import tank_pkg::*; #(
    parameter logic [9:0] B_SIZE = 10'd4,
    parameter logic [9:0] SPEED  = 10'd4,
    parameter logic [9:0] X_MAX  = tank_pkg::X_MAX,
    parameter logic [9:0] Y_MAX  = tank_pkg::Y_MAX
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       load,
    input  logic [9:0] spawn_x,
    input  logic [9:0] spawn_y,
    input  dir_t       spawn_d,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       active,
    output logic       hit
);

    logic [9:0] x, y;
    dir_t       d;
    logic [9:0] dx, dy;

    // Bounds tested at 11 bits so nothing wraps near the screen edges.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            active <= 1'b0;
            x      <= '0;
            y      <= '0;
            d      <= UP;
        end else if (load) begin
            active <= 1'b1;
            x      <= spawn_x;
            y      <= spawn_y;
            d      <= spawn_d;
        end else if (frame_tick && active) begin
            case (d)
                UP:    if ({1'b0, y} < {1'b0, SPEED}) active <= 1'b0;
                       else y <= y - SPEED;
                DOWN:  if ({1'b0, y} + {1'b0, SPEED} + {1'b0, B_SIZE} > {1'b0, Y_MAX}) active <= 1'b0;
                       else y <= y + SPEED;
                LEFT:  if ({1'b0, x} < {1'b0, SPEED}) active <= 1'b0;
                       else x <= x - SPEED;
                RIGHT: if ({1'b0, x} + {1'b0, SPEED} + {1'b0, B_SIZE} > {1'b0, X_MAX}) active <= 1'b0;
                       else x <= x + SPEED;
                default: active <= active;
            endcase
        end
    end

    // Unsigned differences: pixels left of or above the slot wrap large and miss.
    assign dx  = DrawX - x;
    assign dy  = DrawY - y;
    assign hit = active && (dx < B_SIZE) && (dy < B_SIZE);

endmodule

// File: rtl/bullet_ctrl.sv
// Bullet pool controller: frame tick detection, facing, fire cooldown,
// lowest-free-slot spawning, pixel hit OR and live-bullet count.
module bullet_ctrl import tank_pkg::*; #(
    parameter int         NUM_SLOTS = 4,
    parameter logic [9:0] B_SIZE    = 10'd4,
    parameter logic [9:0] SPEED     = 10'd4,
    parameter logic [5:0] COOLDOWN  = 6'd15,
    parameter logic [9:0] TANK_W    = 10'd50,
    parameter logic [9:0] TANK_H    = 10'd50,
    parameter logic [9:0] X_MAX     = tank_pkg::X_MAX,
    parameter logic [9:0] Y_MAX     = tank_pkg::Y_MAX
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       is_shooting,
    input  logic [9:0] tank_X,
    input  logic [9:0] tank_Y,
    input  logic [7:0] keycode,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       is_bullet,
    output logic [3:0] bullet_count,
    output logic       shot_fired
);

    logic                 frame_d, frame_tick;
    dir_t                 dir;
    logic [5:0]           cd;
    logic [NUM_SLOTS-1:0] active, hit, pick, load;
    logic                 any_free, fire_ok;
    logic [3:0]           live;
    logic [9:0]           spawn_x, spawn_y;

    // Free-slot search sees pre-tick active bits, so a slot retiring this
    // cycle cannot be reused until the next one.
    always_comb begin
        pick     = '0;
        any_free = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!active[i] && !any_free) begin
                pick[i]  = 1'b1;
                any_free = 1'b1;
            end
        end
    end

    assign fire_ok = is_shooting && (cd == 6'd0) && any_free;
    assign load    = fire_ok ? pick : '0;
    assign spawn_x = tank_X + (TANK_W >> 1) - (B_SIZE >> 1);
    assign spawn_y = tank_Y + (TANK_H >> 1) - (B_SIZE >> 1);

    always_comb begin
        live = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            live = live + {3'b000, active[i]};
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        bullet_slot #(
            .B_SIZE(B_SIZE), .SPEED(SPEED), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
        ) u_slot (
            .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .load(load[i]),
            .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_d(dir),
            .DrawX(DrawX), .DrawY(DrawY), .active(active[i]), .hit(hit[i])
        );
    end

    assign is_bullet = |hit;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_d      <= 1'b0;
            frame_tick   <= 1'b0;
            dir          <= LEFT;
            cd           <= '0;
            shot_fired   <= 1'b0;
            bullet_count <= '0;
        end else begin
            frame_d      <= frame_clk;
            frame_tick   <= frame_clk && !frame_d;
            shot_fired   <= fire_ok;
            bullet_count <= live;
            case (keycode)
                KEY_W:   dir <= UP;
                KEY_S:   dir <= DOWN;
                KEY_A:   dir <= LEFT;
                KEY_D:   dir <= RIGHT;
                default: dir <= dir;
            endcase
            // A spawn reloads the cooldown even on a tick cycle.
            if (fire_ok)
                cd <= COOLDOWN;
            else if (frame_tick && cd != 6'd0)
                cd <= cd - 6'd1;
        end
    end

endmodule
